// File: rtl/aes_inv_cipher_ctrl_if.sv
// Handshake and key-store bus of the iterative AES inverse-cipher controller.
// slave = controller side, master = source/sink/key-store side.
interface aes_inv_cipher_ctrl_if #(
    parameter int IDXW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [127:0]    ct_in;
    logic [IDXW-1:0] rk_idx;
    logic [127:0]    rk_data;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    pt_out;
    logic            busy;

    modport slave (
        input  in_valid, ct_in, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, pt_out, busy
    );

    modport master (
        output in_valid, ct_in, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, pt_out, busy
    );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher, one round per clock; plaintext valid NR+1 cycles after accept.
// Backpressure: result is held in DONE until out_ready; no new block is taken until IDLE.

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y = gf_inv(b);
    end
endmodule

module aes_inv_cipher_ctrl #(
    parameter int NR   = 14,
    parameter int IDXW = 4
) (
    input logic                  clk,
    input logic                  rst,
    aes_inv_cipher_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);
    localparam logic [IDXW-1:0] FIRST_RD = IDXW'(NR - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        inv_mix_col = {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                       gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                       gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                       gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    state_t          st, st_nx;
    logic [IDXW-1:0] round, round_nx;
    logic [127:0]    state, state_nx;
    logic [127:0]    pt_q, pt_nx;
    logic [127:0]    sr, sb, t, mc;
    logic            in_ready, out_valid, busy;
    logic [IDXW-1:0] rk_idx;

    // Byte k = r + 4c lives at bits [127-8k -: 8]; row r rotates right by r columns
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(r + 4*c) -: 8] = state[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a (sr[127 - 8*g -: 8]),
            .y (sb[127 - 8*g -: 8])
        );
    end

    assign t = sb ^ bus.rk_data;

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = inv_mix_col(t[127 - 32*c -: 32]);
        end
    end

    always_comb begin
        st_nx     = st;
        round_nx  = round;
        state_nx  = state;
        pt_nx     = pt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = '0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = LAST_IDX;
                if (bus.in_valid) begin
                    state_nx = bus.ct_in ^ bus.rk_data;
                    round_nx = FIRST_RD;
                    st_nx    = ROUND;
                end
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = round;
                if (round != '0) begin
                    state_nx = mc;
                    round_nx = round - 1'b1;
                end else begin
                    state_nx = t;
                    pt_nx    = t;
                    st_nx    = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            round <= FIRST_RD;
            state <= '0;
            pt_q  <= '0;
        end else begin
            st    <= st_nx;
            round <= round_nx;
            state <= state_nx;
            pt_q  <= pt_nx;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.rk_idx    = rk_idx;
    assign bus.pt_out    = pt_q;
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: NR=14 and NR=10 instances fed from a bench-expanded key store.
module tb_aes_inv_cipher_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_cipher_ctrl_if #(.IDXW(4)) if14 ();
    aes_inv_cipher_ctrl_if #(.IDXW(4)) if10 ();

    aes_inv_cipher_ctrl #(.NR(14), .IDXW(4)) u_dut14 (.clk(clk), .rst(rst), .bus(if14.slave));
    aes_inv_cipher_ctrl #(.NR(10), .IDXW(4)) u_dut10 (.clk(clk), .rst(rst), .bus(if10.slave));

    logic [127:0] rk14 [0:15];
    logic [127:0] rk10 [0:15];
    logic [7:0]   fsb  [0:255];

    logic         in_valid, out_ready, sel14;
    logic [127:0] ct;

    assign if14.in_valid  = in_valid && sel14;
    assign if10.in_valid  = in_valid && !sel14;
    assign if14.ct_in     = ct;
    assign if10.ct_in     = ct;
    assign if14.out_ready = out_ready;
    assign if10.out_ready = out_ready;
    assign if14.rk_data   = rk14[if14.rk_idx];
    assign if10.rk_data   = rk10[if10.rk_idx];

    wire         s_in_ready  = sel14 ? if14.in_ready  : if10.in_ready;
    wire         s_out_valid = sel14 ? if14.out_valid : if10.out_valid;
    wire         s_busy      = sel14 ? if14.busy      : if10.busy;
    wire [3:0]   s_rk_idx    = sel14 ? if14.rk_idx    : if10.rk_idx;
    wire [127:0] s_pt        = sel14 ? if14.pt_out    : if10.pt_out;

    int acc14 = 0;
    int acc10 = 0;
    always @(posedge clk) begin
        if (if14.in_valid && if14.in_ready) acc14 <= acc14 + 1;
        if (if10.in_valid && if10.in_ready) acc10 <= acc10 + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fsb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fsb[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 8) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic accept(input int nr, input logic [127:0] c, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        ct       = c;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle in_ready"}, s_in_ready, 1);
        check({tag, " idle rk_idx"}, s_rk_idx, nr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ct       = {4{32'hdeadbeef}};
    endtask

    task automatic collect(input int nr, input logic [127:0] exp, input string tag, input bit noise);
        int cyc;
        bit rk_ok, busy_ok;
        cyc     = 0;
        rk_ok   = 1'b1;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!s_out_valid) begin
                if (s_rk_idx !== 4'(nr - cyc)) rk_ok = 1'b0;
                if (s_in_ready !== 1'b0 || s_busy !== 1'b1) busy_ok = 1'b0;
                if (noise) begin
                    in_valid = 1'($urandom_range(0, 1));
                    ct       = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end while (!s_out_valid && cyc < 40);
        in_valid = 1'b0;
        check({tag, " latency"}, cyc, nr + 1);
        check({tag, " rk_idx sequence ok"}, rk_ok, 1);
        check({tag, " round in_ready0/busy1 ok"}, busy_ok, 1);
        check({tag, " pt_out"}, s_pt, exp);
        check({tag, " done in_ready"}, s_in_ready, 0);
        check({tag, " done busy"}, s_busy, 1);
    endtask

    task automatic after_handshake(input logic [127:0] exp, input string tag);
        @(negedge clk);
        check({tag, " post out_valid"}, s_out_valid, 0);
        check({tag, " post in_ready"}, s_in_ready, 1);
        check({tag, " post pt retained"}, s_pt, exp);
    endtask

    typedef struct {
        int           nk;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        string        tag;
    } vec_t;

    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTF    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [3];
        logic [127:0] pt_a;
        int           n, acc_before;
        bit           hold_ok;

        vecs[0] = '{nk: 8, key: KEY256, ct: CT256, pt: PTF, tag: "fips256"};
        vecs[1] = '{nk: 4, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt: PTF, tag: "fips128"};
        vecs[2] = '{nk: 4, key: KEYB, ct: CTB, pt: PTB, tag: "appb128"};

        build_sbox();
        expand(8, KEY256);
        expand(4, vecs[1].key);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel14     = 1'b1;
        ct        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset14 in_ready",  if14.in_ready,  1);
        check("reset14 out_valid", if14.out_valid, 0);
        check("reset14 pt_out",    if14.pt_out,    0);
        check("reset14 busy",      if14.busy,      0);
        check("reset14 rk_idx",    if14.rk_idx,    14);
        check("reset10 in_ready",  if10.in_ready,  1);
        check("reset10 out_valid", if10.out_valid, 0);
        check("reset10 rk_idx",    if10.rk_idx,    10);

        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            expand(vecs[v].nk, vecs[v].key);
            sel14 = (vecs[v].nk == 8);
            accept(vecs[v].nk + 6, vecs[v].ct, vecs[v].tag);
            collect(vecs[v].nk + 6, vecs[v].pt, vecs[v].tag, 1'b0);
            after_handshake(vecs[v].pt, vecs[v].tag);
        end

        // Backpressure: DONE held for 5 cycles
        expand(8, KEY256);
        sel14     = 1'b1;
        out_ready = 1'b0;
        accept(14, CT256, "bp");
        collect(14, PTF, "bp", 1'b0);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_out_valid !== 1'b1 || s_pt !== PTF || s_in_ready !== 1'b0) hold_ok = 1'b0;
        end
        check("bp hold stable", hold_ok, 1);
        out_ready = 1'b1;
        after_handshake(PTF, "bp");

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        in_valid = 1'b1;
        ct       = CT256;
        n        = 0;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        n    = 0;
        pt_a = '0;
        do begin
            @(negedge clk);
            n++;
            if (s_out_valid) pt_a = s_pt;
        end while (!s_in_ready && n < 40);
        check("b2b accept gap", n, 16);
        check("b2b first pt", pt_a, PTF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(14, PTF, "b2b second", 1'b0);
        after_handshake(PTF, "b2b second");

        // in_valid noise while busy on the NR=10 instance
        expand(4, KEYB);
        sel14      = 1'b0;
        acc_before = acc10;
        accept(10, CTB, "noise");
        collect(10, PTB, "noise", 1'b1);
        after_handshake(PTB, "noise");
        check("noise acceptances", acc10 - acc_before, 1);

        // Reset while round = 7
        sel14 = 1'b1;
        accept(14, CT256, "rst");
        n = 0;
        while (s_rk_idx !== 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst reached round 7", s_rk_idx, 7);
        check("rst busy at round 7", s_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", s_out_valid, 0);
        check("rst pt_out",    s_pt,        0);
        check("rst in_ready",  s_in_ready,  1);
        check("rst busy",      s_busy,      0);
        accept(14, CT256, "rst fresh");
        collect(14, PTF, "rst fresh", 1'b0);
        after_handshake(PTF, "rst fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher controller: the decryption counterpart to the team's AES encryption control path.
- Accepts one 128-bit ciphertext block through a valid/ready handshake.
- Runs one inverse round per clock, fetching round keys from an external asynchronous-read key store by index.
- Emits the 128-bit plaintext through a valid/ready handshake; sits between the key-schedule store and the downstream hash/data consumer.

Parameters:
- NR, 14, number of rounds; legal values are 10, 12 and 14 (AES-128/192/256). The key store must hold keys 0..NR.
- IDXW, 4, width of the round-key index port.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext block available.
- in_ready  output  1  block accepted when in_valid and in_ready are both high.
- ct_in  input  128  ciphertext; byte 0 = bits[127:120], column-major state order per FIPS-197.
- rk_idx  output  IDXW  index of the round key requested this cycle.
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
- pt_out  output  128  plaintext, same byte order as ct_in.
- busy  output  1  high in ROUND and DONE.

Behaviour:
- Reset (rst high at a clock edge): FSM goes to IDLE, round counter = NR-1, state register = 0, in_ready = 1 in the following cycle, out_valid = 0, pt_out = 0, busy = 0.
- Reset mid-operation aborts the block with no output; the partial state is discarded.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1; rk_idx = NR.
  - On in_valid: state <= ct_in XOR rk_data; round <= NR-1; go to ROUND.
- ROUND:
  - in_ready = 0; rk_idx = round.
  - Each cycle: t = InvSubBytes(InvShiftRows(state)) XOR rk_data.
  - If round != 0: state <= InvMixColumns(t); round <= round-1.
  - If round == 0: state <= t; go to DONE.
- DONE:
  - out_valid = 1; pt_out = state, held stable until the handshake completes; in_ready = 0.
  - On out_ready: out_valid cleared next cycle; go to IDLE.
  - No same-cycle accept of a new block in DONE.
- Latency: acceptance edge = cycle 0; out_valid first high in cycle NR+1 (cycle 15 for NR=14).
- Throughput: one block per NR+2 cycles with out_ready held high.
- rk_idx outside IDLE/ROUND: drive 0.
- in_valid while busy is ignored; ct_in is not sampled.
- rk_data changes outside the cycle that indexes it have no effect.
- Arithmetic:
  - InvMixColumns over GF(2^8) with polynomial 0x11B, coefficients {0e,0b,0d,09}.
  - xtime: shift left by 1, XOR 0x1B on carry-out.
  - All XORs are 128-bit bytewise with no carries.
- InvSubBytes: sixteen instances of the team's combinational inverse S-box leaf (8-bit in / 8-bit out).
- No combinational path from in_valid or out_ready to in_ready or out_valid; both handshake outputs are state-decoded.
- pt_out is valid only while out_valid is high; it retains its last value otherwise.

Test Plan:
- NR=14, bench key store expanded from key 000102…1f; ct_in = 8ea2b7ca516745bfeafc49904b496089 -> pt_out = 00112233445566778899aabbccddeeff, out_valid rises exactly 15 cycles after acceptance, rk_idx sequence 14,13,…,0.
- NR=10, key 000102…0f, ct_in = 69c4e0d86a7b0430d8cdb78070b4c55a -> pt_out = 00112233445566778899aabbccddeeff at cycle 11.
- Backpressure: hold out_ready low for 5 cycles in DONE -> out_valid and pt_out stable, in_ready stays 0; release -> IDLE next cycle and in_ready = 1.
- Back-to-back: two FIPS blocks with in_valid and out_ready held high -> second block accepted exactly 16 cycles after the first (NR=14); both plaintexts correct.
- Busy stimulus: toggle in_valid with garbage ct_in during ROUND -> result unchanged, no extra acceptance.
- Reset at ROUND cycle with round = 7 -> next cycle in IDLE, out_valid 0, pt_out 0; a fresh FIPS block afterwards decrypts correctly.
